// File: rtl/prbs_pattern_gen_pkg.sv
// Shared types for the PRBS pattern generator: order codes, polynomial table and FSM states.
package prbs_pattern_gen_pkg;

  localparam int LFSR_W = 31;

  typedef logic [LFSR_W-1:0] lfsr_t;

  typedef enum logic [2:0] {
    ORD_PRBS7  = 3'd0,
    ORD_PRBS9  = 3'd1,
    ORD_PRBS15 = 3'd2,
    ORD_PRBS23 = 3'd3,
    ORD_PRBS31 = 3'd4
  } order_t;

  typedef enum logic [1:0] {
    IDLE,
    SEED,
    RUN
  } state_t;

  // taps: the two register bits XORed into the feedback; mask: the low N bits of the register
  typedef struct packed {
    lfsr_t taps;
    lfsr_t mask;
  } poly_t;

  function automatic order_t decode_order(input logic [2:0] code);
    case (code)
      3'd1:    return ORD_PRBS9;
      3'd2:    return ORD_PRBS15;
      3'd3:    return ORD_PRBS23;
      3'd4:    return ORD_PRBS31;
      default: return ORD_PRBS7;
    endcase
  endfunction

  function automatic poly_t poly_of(input order_t ord);
    case (ord)
      ORD_PRBS9:  return '{taps: 31'h0000_0110, mask: 31'h0000_01FF};
      ORD_PRBS15: return '{taps: 31'h0000_6000, mask: 31'h0000_7FFF};
      ORD_PRBS23: return '{taps: 31'h0042_0000, mask: 31'h007F_FFFF};
      ORD_PRBS31: return '{taps: 31'h4800_0000, mask: 31'h7FFF_FFFF};
      default:    return '{taps: 31'h0000_0060, mask: 31'h0000_007F};
    endcase
  endfunction

endpackage

// File: rtl/prbs_pattern_gen_if.sv
// Word stream from the PRBS generator to the serializer/checker path.
interface prbs_pattern_gen_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/prbs_pattern_gen_lfsr_step.sv
// Unrolled Fibonacci LFSR: advances DATA_W steps and returns the feedback bits MSB-first.
module prbs_lfsr_step
  import prbs_pattern_gen_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  lfsr_t             state_in,
  input  order_t            order,
  output lfsr_t             state_out,
  output logic [DATA_W-1:0] word
);

  poly_t poly;
  lfsr_t s;
  logic  fb;

  always_comb begin
    poly = poly_of(order);
    s    = state_in;
    fb   = 1'b0;
    word = '0;
    for (int i = 0; i < DATA_W; i++) begin
      fb   = ^(s & poly.taps);
      s    = ((s << 1) | lfsr_t'(fb)) & poly.mask;
      word = (word << 1) | DATA_W'(fb);
    end
    state_out = s;
  end

endmodule

// File: rtl/prbs_pattern_gen.sv
// PRBS test-word generator paced by a sampled ref_clock, with error injection and status counters.
//
//  state | meaning
//  IDLE  | held by channel_reset, no word offered
//  SEED  | latch order code, load all-ones seed
//  RUN   | generate one word per ref_clock rise
module prbs_pattern_gen
  import prbs_pattern_gen_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               ref_clock,
  input  logic               channel_reset,
  input  logic [2:0]         datawidth,
  input  logic               err_inject,
  prbs_pattern_gen_if.master stream,
  output logic [CNT_W-1:0]   word_count,
  output logic               overrun,
  output logic               cfg_err
);

  state_t            state;
  logic              ref_sync1, ref_sync2, ref_prev, tick_q;
  logic [2:0]        cur_order;
  lfsr_t             lfsr, lfsr_next;
  logic [DATA_W-1:0] word;
  logic              inject_pending;
  logic              accept;
  poly_t             seed_poly;

  assign accept    = stream.out_valid & stream.out_ready;
  assign seed_poly = poly_of(decode_order(datawidth));

  prbs_lfsr_step #(.DATA_W(DATA_W)) u_step (
    .state_in  (lfsr),
    .order     (decode_order(cur_order)),
    .state_out (lfsr_next),
    .word      (word)
  );

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state           <= IDLE;
      ref_sync1       <= 1'b0;
      ref_sync2       <= 1'b0;
      ref_prev        <= 1'b0;
      tick_q          <= 1'b0;
      cur_order       <= 3'd0;
      lfsr            <= '0;
      inject_pending  <= 1'b0;
      stream.out_data <= '0;
      stream.out_valid <= 1'b0;
      word_count      <= '0;
      overrun         <= 1'b0;
      cfg_err         <= 1'b0;
    end else begin
      ref_sync1 <= ref_clock;
      ref_sync2 <= ref_sync1;
      ref_prev  <= ref_sync2;
      // registered edge pulse puts the word on the third edge after ref_clock is first sampled
      tick_q    <= ref_sync2 & ~ref_prev;

      if (datawidth >= 3'd5) cfg_err <= 1'b1;
      if (accept && (word_count != {CNT_W{1'b1}})) word_count <= word_count + CNT_W'(1);
      if (err_inject) inject_pending <= 1'b1;

      if (channel_reset) begin
        state            <= IDLE;
        stream.out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            stream.out_valid <= 1'b0;
            state            <= SEED;
          end
          SEED: begin
            cur_order        <= datawidth;
            lfsr             <= seed_poly.mask;
            inject_pending   <= 1'b0;
            stream.out_valid <= 1'b0;
            state            <= RUN;
          end
          RUN: begin
            if (datawidth != cur_order) begin
              stream.out_valid <= 1'b0;
              state            <= SEED;
            end else if (tick_q) begin
              if (!stream.out_valid || stream.out_ready) begin
                stream.out_data  <= word ^ DATA_W'(inject_pending | err_inject);
                stream.out_valid <= 1'b1;
                lfsr             <= lfsr_next;
                inject_pending   <= 1'b0;
              end else begin
                overrun <= 1'b1;
              end
            end else if (accept) begin
              stream.out_valid <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_pattern_gen.sv
// Self-checking bench for prbs_pattern_gen: reset, latency, handshake corners, vector table, random stream.
module tb_prbs_pattern_gen;

  localparam int CNT_W = 6;

  logic             clock = 1'b0;
  logic             rst_n;
  logic             ref_clock;
  logic             channel_reset;
  logic [2:0]       datawidth;
  logic             err_inject;
  logic [CNT_W-1:0] word_count;
  logic             overrun;
  logic             cfg_err;

  prbs_pattern_gen_if #(.DATA_W(8)) stream ();

  prbs_pattern_gen #(.DATA_W(8), .CNT_W(CNT_W)) dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .ref_clock     (ref_clock),
    .channel_reset (channel_reset),
    .datawidth     (datawidth),
    .err_inject    (err_inject),
    .stream        (stream),
    .word_count    (word_count),
    .overrun       (overrun),
    .cfg_err       (cfg_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  code;
    logic [31:0] words;
    logic        cfg;
  } vec_t;

  vec_t       tbl [7];
  int         checks = 0;
  int         errors = 0;
  int         n_acc  = 0;
  bit         acc_seen;
  logic [7:0] acc_data;
  bit         mon_en = 0;
  bit         hold_prev = 0;
  logic [7:0] prev_data;
  int         mdl_n, mdl_k;
  bit         hist [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_wc();
    return (n_acc > 63) ? 32'd63 : 32'(n_acc);
  endfunction

  // reference: a[n] = a[n-N] ^ a[n-k] over a history that starts as N ones
  task automatic mdl_seed(input logic [2:0] code);
    case (code)
      3'd1:    begin mdl_n = 9;  mdl_k = 5;  end
      3'd2:    begin mdl_n = 15; mdl_k = 14; end
      3'd3:    begin mdl_n = 23; mdl_k = 18; end
      3'd4:    begin mdl_n = 31; mdl_k = 28; end
      default: begin mdl_n = 7;  mdl_k = 6;  end
    endcase
    hist.delete();
    repeat (mdl_n) hist.push_back(1'b1);
  endtask

  task automatic mdl_word(output logic [7:0] w);
    bit b;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      b = hist[0] ^ hist[mdl_n - mdl_k];
      hist.push_back(b);
      void'(hist.pop_front());
      w = {w[6:0], b};
    end
  endtask

  task automatic cyc();
    logic [7:0] w;
    @(negedge clock);
    if (stream.out_valid && stream.out_ready) begin
      n_acc++;
      acc_seen = 1;
      acc_data = stream.out_data;
      if (mon_en) begin
        mdl_word(w);
        check("rand_word", 32'(stream.out_data), 32'(w));
      end
    end
    if (mon_en) begin
      if (hold_prev) begin
        check("hold_data", 32'(stream.out_data), 32'(prev_data));
        check("hold_valid", 32'(stream.out_valid), 32'd1);
      end
      hold_prev = stream.out_valid && !stream.out_ready;
      prev_data = stream.out_data;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic get_word(output logic [7:0] w);
    stream.out_ready = 1'b1;
    acc_seen  = 0;
    ref_clock = 1'b1;
    for (int i = 0; i < 10 && !acc_seen; i++) cyc();
    ref_clock = 1'b0;
    check("word_timeout", 32'(acc_seen), 32'd1);
    w = acc_data;
    repeat (3) cyc();
  endtask

  task automatic hold_word();
    stream.out_ready = 1'b0;
    ref_clock = 1'b1;
    repeat (5) cyc();
    ref_clock = 1'b0;
    repeat (2) cyc();
  endtask

  task automatic restart(input logic [2:0] code);
    channel_reset = 1'b1;
    repeat (2) cyc();
    datawidth     = code;
    channel_reset = 1'b0;
    repeat (3) cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  w;
    logic [31:0] ws;
    int          ref_left;

    tbl[0] = '{3'd0, 32'h020C28F2, 1'b0};
    tbl[1] = '{3'd1, 32'h07BE2E64, 1'b0};
    tbl[2] = '{3'd2, 32'h0002000C, 1'b0};
    tbl[3] = '{3'd3, 32'h00003E00, 1'b0};
    tbl[4] = '{3'd4, 32'h0000000E, 1'b0};
    tbl[5] = '{3'd6, 32'h020C28F2, 1'b1};
    tbl[6] = '{3'd0, 32'h020C28F2, 1'b1};

    rst_n = 1'b0; ref_clock = 1'b0; channel_reset = 1'b0;
    datawidth = 3'd0; err_inject = 1'b0; stream.out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", 32'(stream.out_valid), 32'd0);
    check("rst_data", 32'(stream.out_data), 32'd0);
    check("rst_count", 32'(word_count), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    rst_n = 1'b1;
    repeat (3) cyc();

    // first word latency and value
    ref_clock = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(posedge clock);
      #1;
      check("lat_valid_low", 32'(stream.out_valid), 32'd0);
    end
    @(posedge clock);
    #1;
    check("lat_valid_high", 32'(stream.out_valid), 32'd1);
    check("first_word", 32'(stream.out_data), 32'h02);
    check("first_overrun", 32'(overrun), 32'd0);
    ref_clock = 1'b0;
    repeat (2) cyc();

    // second rise while the word is still held
    ref_clock = 1'b1;
    repeat (5) cyc();
    ref_clock = 1'b0;
    cyc();
    check("held_data", 32'(stream.out_data), 32'h02);
    check("held_valid", 32'(stream.out_valid), 32'd1);
    check("overrun_set", 32'(overrun), 32'd1);
    check("held_count", 32'(word_count), 32'd0);
    stream.out_ready = 1'b1;
    cyc();
    stream.out_ready = 1'b0;
    check("accept_count", 32'(word_count), 32'd1);
    check("accept_clears", 32'(stream.out_valid), 32'd0);
    get_word(w);
    check("after_drop_word", 32'(w), 32'h0C);

    // error injection before the first tick
    restart(3'd0);
    err_inject = 1'b1;
    cyc();
    err_inject = 1'b0;
    repeat (2) cyc();
    get_word(w);
    check("inject_word", 32'(w), 32'h03);
    get_word(w);
    check("inject_next", 32'(w), 32'h0C);
    get_word(w);
    check("inject_third", 32'(w), 32'h28);

    // order change while a word is held
    hold_word();
    check("pre_switch_data", 32'(stream.out_data), 32'hF2);
    check("pre_switch_valid", 32'(stream.out_valid), 32'd1);
    datawidth = 3'd2;
    cyc();
    check("switch_drop", 32'(stream.out_valid), 32'd0);
    repeat (2) cyc();
    ws = 32'h00020000;
    for (int j = 0; j < 3; j++) begin
      get_word(w);
      check("switch_prbs15", 32'(w), 32'(ws[31:24]));
      ws = ws << 8;
    end

    // channel_reset mid-stream
    hold_word();
    check("cr_held", 32'(stream.out_data), 32'h0C);
    channel_reset = 1'b1;
    cyc();
    check("cr_valid", 32'(stream.out_valid), 32'd0);
    datawidth     = 3'd0;
    channel_reset = 1'b0;
    check("cr_count_kept", 32'(word_count), exp_wc());
    check("cr_overrun_kept", 32'(overrun), 32'd1);
    repeat (3) cyc();
    get_word(w);
    check("cr_restart0", 32'(w), 32'h02);
    get_word(w);
    check("cr_restart1", 32'(w), 32'h0C);

    // vector table: first four words per order code
    for (int r = 0; r < 7; r++) begin
      restart(tbl[r].code);
      ws = tbl[r].words;
      for (int j = 0; j < 4; j++) begin
        get_word(w);
        check($sformatf("tbl%0d_w%0d", r, j), 32'(w), 32'(ws[31:24]));
        ws = ws << 8;
      end
      check($sformatf("tbl%0d_cfg", r), 32'(cfg_err), 32'(tbl[r].cfg));
      check($sformatf("tbl%0d_count", r), 32'(word_count), exp_wc());
    end

    // random ready/ref_clock against the bit-recurrence model
    for (int o = 0; o < 5; o++) begin
      mon_en = 0;
      stream.out_ready = 1'b1;
      ref_clock = 1'b0;
      restart(3'(o));
      mdl_seed(3'(o));
      hold_prev = 0;
      mon_en    = 1;
      ref_left  = $urandom_range(1, 4);
      repeat (400) begin
        stream.out_ready = ($urandom_range(0, 2) != 0);
        if (ref_left == 0) begin
          ref_clock = ~ref_clock;
          ref_left  = $urandom_range(1, 4);
        end else begin
          ref_left--;
        end
        cyc();
      end
      mon_en = 0;
      check($sformatf("rand%0d_count", o), 32'(word_count), exp_wc());
    end
    check("count_saturated", 32'(word_count), 32'd63);
    check("final_cfg_err", 32'(cfg_err), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
